// File: rtl/sync_fifo_wconv_pkg.sv
// Shared helpers for the width-converting FIFO: ratio derivation and read-lane ordering.
package sync_fifo_wconv_pkg;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int wconv_shift(input int unsigned wr_w, input int unsigned rd_w);
    return clog2(wr_w / rd_w);
  endfunction

  // Physical lane for a sub-word index; mirrored when the MSB lane leads.
  function automatic int unsigned lane_sel(input int unsigned sub, input int unsigned shift,
                                           input bit lsb_first);
    return lsb_first ? sub : ((32'd1 << shift) - 32'd1 - sub);
  endfunction

endpackage

// File: rtl/sync_fifo_wconv_if.sv
// Handshake, level and config bundle of the width-converting FIFO.
interface sync_fifo_wconv_if #(
  parameter int WR_DATA_WIDTH  = 64,
  parameter int RD_DATA_WIDTH  = 16,
  parameter int WR_DEPTH_WIDTH = 4
);
  localparam int RD_DEPTH_WIDTH =
    WR_DEPTH_WIDTH + sync_fifo_wconv_pkg::wconv_shift(WR_DATA_WIDTH, RD_DATA_WIDTH);

  logic                      wr_en;
  logic [WR_DATA_WIDTH-1:0]  wr_data;
  logic                      wr_full;
  logic                      almost_full;
  logic [WR_DEPTH_WIDTH:0]   wr_water_level;
  logic                      rd_en;
  logic [RD_DATA_WIDTH-1:0]  rd_data;
  logic                      rd_valid;
  logic                      rd_empty;
  logic                      almost_empty;
  logic [RD_DEPTH_WIDTH:0]   rd_water_level;
  logic [WR_DEPTH_WIDTH:0]   cfg_afull_th;
  logic [RD_DEPTH_WIDTH:0]   cfg_aempty_th;
  logic                      err_clr;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output wr_en, wr_data, rd_en, cfg_afull_th, cfg_aempty_th, err_clr,
    input  wr_full, almost_full, wr_water_level, rd_data, rd_valid, rd_empty,
           almost_empty, rd_water_level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, cfg_afull_th, cfg_aempty_th, err_clr,
    output wr_full, almost_full, wr_water_level, rd_data, rd_valid, rd_empty,
           almost_empty, rd_water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_wconv_ram.sv
// Simple dual-port storage with a registered read port; the array itself is never reset.
module sync_fifo_wconv_ram #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_wconv.sv
// Single-clock wide-to-narrow FIFO with registered flags/levels and selectable lane order.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_WCONV_ERR_EN.
module sync_fifo_wconv
  import sync_fifo_wconv_pkg::*;
#(
  parameter int WR_DATA_WIDTH  = 64,
  parameter int RD_DATA_WIDTH  = 16,
  parameter int WR_DEPTH_WIDTH = 4,
  parameter int LSB_FIRST      = 1
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_wconv_if.slave bus
);
  localparam int SHIFT          = wconv_shift(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + SHIFT;
  localparam int NUM_LANES      = 1 << SHIFT;
  localparam int LW             = (SHIFT == 0) ? 1 : SHIFT;

  typedef logic [WR_DEPTH_WIDTH:0] wptr_t;
  typedef logic [RD_DEPTH_WIDTH:0] rptr_t;
  localparam wptr_t FULL_LVL  = wptr_t'(1) << WR_DEPTH_WIDTH;
  localparam rptr_t LANE_MASK = rptr_t'(NUM_LANES - 1);

  wptr_t wr_ptr, wr_nxt, wr_lvl, wr_lvl_nxt;
  rptr_t rd_ptr, rd_nxt, rd_lvl, rd_lvl_nxt;
  logic  full_q, empty_q, afull_q, aempty_q, rd_vld_q;
  logic  wr_acc, rd_acc;
  logic [LW-1:0] lane, lane_q;
  logic [WR_DATA_WIDTH-1:0] ram_q;
  logic [NUM_LANES-1:0][RD_DATA_WIDTH-1:0] lanes;

  // Acceptance uses the registered flags, so a same-cycle read never rescues a write at full.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;
  assign lane   = LW'(lane_sel(32'(rd_ptr & LANE_MASK), SHIFT, LSB_FIRST != 0));

  always_comb begin
    wr_nxt     = wr_ptr + wptr_t'(wr_acc);
    rd_nxt     = rd_ptr + rptr_t'(rd_acc);
    // A partially drained wide slot still counts as occupied (floor of rd_ptr).
    wr_lvl_nxt = wr_nxt - wptr_t'(rd_nxt >> SHIFT);
    rd_lvl_nxt = (rptr_t'(wr_nxt) << SHIFT) - rd_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_lvl   <= '0;
      rd_lvl   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rd_vld_q <= 1'b0;
      lane_q   <= '0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      wr_lvl   <= wr_lvl_nxt;
      rd_lvl   <= rd_lvl_nxt;
      full_q   <= (wr_lvl_nxt == FULL_LVL);
      empty_q  <= (rd_lvl_nxt == '0);
      afull_q  <= (wr_lvl_nxt >= bus.cfg_afull_th);
      aempty_q <= (rd_lvl_nxt <= bus.cfg_aempty_th);
      rd_vld_q <= rd_acc;
      if (rd_acc) lane_q <= lane;
    end
  end

  sync_fifo_wconv_ram #(.DW(WR_DATA_WIDTH), .AW(WR_DEPTH_WIDTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[RD_DEPTH_WIDTH-1:SHIFT]),
    .rdata (ram_q)
  );

  // RAM word and lane index both hold between reads, so rd_data holds too.
  assign lanes              = ram_q;
  assign bus.rd_data        = lanes[lane_q];
  assign bus.rd_valid       = rd_vld_q;
  assign bus.wr_full        = full_q;
  assign bus.rd_empty       = empty_q;
  assign bus.almost_full    = afull_q;
  assign bus.almost_empty   = aempty_q;
  assign bus.wr_water_level = wr_lvl;
  assign bus.rd_water_level = rd_lvl;

`ifdef SYNC_FIFO_WCONV_ERR_EN
  logic ovf_q, udf_q;
  // A new error event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en & full_q)  | (ovf_q & ~bus.err_clr);
      udf_q <= (bus.rd_en & empty_q) | (udf_q & ~bus.err_clr);
    end
  end
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule
